// File: rtl/edf_pkg.sv
// Shared types for the EDF datapath: label/data widths and the FIFO entry layout.
package edf_pkg;

  localparam int unsigned LABEL_W = 8;
  localparam int unsigned DATA_W  = 8;

  typedef logic [LABEL_W-1:0] label_t;
  typedef logic [DATA_W-1:0]  data_t;

  // Matches prio_label_fifo din: label in the upper byte, payload in the lower.
  typedef struct packed {
    label_t label;
    data_t  data;
  } entry_t;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/edf_deadline_labeler_if.sv
// Packet intake and priority-FIFO write port of the deadline labeler.
interface edf_deadline_labeler_if;
  import edf_pkg::*;

  logic   pkt_valid;
  logic   pkt_ready;
  label_t pkt_rel_dl;
  data_t  pkt_data;
  logic   fifo_full;
  logic   fifo_we;
  entry_t fifo_din;

  modport master (
    output pkt_valid, pkt_rel_dl, pkt_data, fifo_full,
    input  pkt_ready, fifo_we, fifo_din
  );

  modport slave (
    input  pkt_valid, pkt_rel_dl, pkt_data, fifo_full,
    output pkt_ready, fifo_we, fifo_din
  );

endinterface

// File: rtl/edf_time_base.sv
// Free-running time base: prescaler of TICK_DIV cycles driving an 8-bit modular tick counter.
module edf_time_base
  import edf_pkg::*;
#(
  parameter int unsigned TICK_DIV = 10
) (
  input  logic   clk,
  input  logic   rst_n,
  output label_t now,
  output logic   tick
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PLast = PW'(TICK_DIV - 1);

  logic [PW-1:0] presc_q, presc_d;
  label_t        now_q, now_d;

  always_comb begin
    tick    = (presc_q == PLast);
    presc_d = tick ? '0 : presc_q + 1'b1;
    now_d   = tick ? now_q + 8'd1 : now_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      now_q   <= '0;
    end else begin
      presc_q <= presc_d;
      now_q   <= now_d;
    end
  end

  assign now = now_q;

endmodule

// File: rtl/edf_deadline_labeler.sv
// Turns relative deadlines into absolute 8-bit labels and feeds the priority FIFO through a
// single-entry output stage; expired packets are dropped, out-of-range deadlines clamped.
module edf_deadline_labeler
  import edf_pkg::*;
#(
  parameter int unsigned TICK_DIV = 10,
  parameter int unsigned MIN_DL   = 4,
  parameter int unsigned MAX_DL   = 200
) (
  input  logic                   clk,
  input  logic                   rst_n,
  edf_deadline_labeler_if.slave  bus,
  output label_t                 now,
  output logic [15:0]            drop_cnt,
  output logic [15:0]            clamp_cnt
);

  localparam label_t MinDl = label_t'(MIN_DL);
  localparam label_t MaxDl = label_t'(MAX_DL);

  label_t      now_w;
  logic        unused_tick;
  entry_t      out_q, out_d;
  logic        pend_q, pend_d;
  logic [15:0] drop_q, drop_d;
  logic [15:0] clamp_q, clamp_d;
  label_t      dl_eff;
  logic        drop, clamp, accept, load, we;

  edf_time_base #(
    .TICK_DIV (TICK_DIV)
  ) u_time_base (
    .clk   (clk),
    .rst_n (rst_n),
    .now   (now_w),
    .tick  (unused_tick)
  );

  always_comb begin
    drop   = (bus.pkt_rel_dl == '0);
    clamp  = 1'b0;
    dl_eff = bus.pkt_rel_dl;
    if (!drop && bus.pkt_rel_dl < MinDl) begin
      clamp  = 1'b1;
      dl_eff = MinDl;
    end else if (bus.pkt_rel_dl > MaxDl) begin
      clamp  = 1'b1;
      dl_eff = MaxDl;
    end
  end

  // Ready is gated by rst_n so nothing is offered as accepted while reset is asserted.
  assign bus.pkt_ready = rst_n & (~pend_q | ~bus.fifo_full);
  assign we            = pend_q & ~bus.fifo_full;
  assign accept        = bus.pkt_valid & bus.pkt_ready;
  assign load          = accept & ~drop;

  always_comb begin
    out_d   = out_q;
    pend_d  = pend_q;
    drop_d  = drop_q;
    clamp_d = clamp_q;
    if (load) begin
      // Pre-tick now: a tick on this same edge must not shift the label.
      out_d.label = now_w + dl_eff;
      out_d.data  = bus.pkt_data;
      pend_d      = 1'b1;
    end else if (we) begin
      pend_d = 1'b0;
    end
    if (accept && drop) begin
      drop_d = sat_inc(drop_q);
    end
    if (accept && clamp) begin
      clamp_d = sat_inc(clamp_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q   <= '0;
      pend_q  <= 1'b0;
      drop_q  <= '0;
      clamp_q <= '0;
    end else begin
      out_q   <= out_d;
      pend_q  <= pend_d;
      drop_q  <= drop_d;
      clamp_q <= clamp_d;
    end
  end

  assign bus.fifo_we  = we;
  assign bus.fifo_din = out_q;
  assign now          = now_w;
  assign drop_cnt     = drop_q;
  assign clamp_cnt    = clamp_q;

endmodule
